ready_list_manager: RTL and testbench

- Task ready-list and TCB table for the hardware RTOS; it is the supply side of the scheduler interface.
- Software manages entries through a valid/ready command port. The block stores per-task priority, ready state and TCB address.
- A sequential scan publishes the highest ready priority, the pointer to the highest-priority task and the round-robin next task to the scheduler.
- It returns the TCB address for the scheduler's read pointer.

---
 rtl/ready_list_manager.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ready_list_manager.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ready_list_manager.sv
// ready_list_manager
//   Task ready-list and TCB table for the hardware RTOS. Software creates,
//   readies, blocks and deletes task entries via a command port; a sequential
//   scan publishes the highest ready priority, the lowest-index task at that
//   priority and the round-robin successor to the scheduler.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op/ptr/pri/tcb     command payload (00 create, 01 ready, 10 block, 11 delete)
//   cmd_err_out            one-cycle pulse after a rejected command
//   tick_in                system tick (level); its rising edge advances round-robin
//   addrread_in            TCB lookup index
//   tcbtask_out            registered TCB address of addrread_in (0 if invalid)
//   highpriority_out       highest ready priority
//   ptr_hpritask_out       lowest-index ready task at that priority
//   ptr_nexttask_out       round-robin successor at that priority
//   scan_busy_out          high while the scan/update sequence is running
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready are
// both high. cmd_ready is high only in IDLE with no rescan pending and never
// while (or in the cycle right after) reset is asserted. cmd_valid may be held
// indefinitely; the payload must stay stable until the transfer.
module ready_list_manager #(
  parameter int NTASKS = 16,
  parameter int PRI_W  = 6,
  parameter int PTR_W  = 8,
  parameter int TCB_W  = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PTR_W-1:0] cmd_ptr,
  input  logic [PRI_W-1:0] cmd_pri,
  input  logic [TCB_W-1:0] cmd_tcb,
  output logic             cmd_err_out,
  input  logic             tick_in,
  input  logic [PTR_W-1:0] addrread_in,
  output logic [TCB_W-1:0] tcbtask_out,
  output logic [PRI_W-1:0] highpriority_out,
  output logic [PTR_W-1:0] ptr_hpritask_out,
  output logic [PTR_W-1:0] ptr_nexttask_out,
  output logic             scan_busy_out
);

  localparam int IDX_W = (NTASKS > 1) ? $clog2(NTASKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTASKS - 1);

  localparam logic [1:0] OP_CREATE = 2'b00;
  localparam logic [1:0] OP_READY  = 2'b01;
  localparam logic [1:0] OP_BLOCK  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             init_done_q, init_done_d;
  logic             tick_q, tick_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             best_found_q, best_found_d;
  logic             next_found_q, next_found_d;
  logic [PRI_W-1:0] best_pri_q, best_pri_d;
  logic [PTR_W-1:0] best_hptr_q, best_hptr_d;
  logic [PTR_W-1:0] best_nptr_q, best_nptr_d;

  logic             valid_q [NTASKS];
  logic             valid_d [NTASKS];
  logic             ready_q [NTASKS];
  logic             ready_d [NTASKS];
  logic [PRI_W-1:0] pri_q   [NTASKS];
  logic [PRI_W-1:0] pri_d   [NTASKS];
  logic [TCB_W-1:0] tcb_q   [NTASKS];
  logic [TCB_W-1:0] tcb_d   [NTASKS];

  logic [PRI_W-1:0] hpri_q, hpri_d;
  logic [PTR_W-1:0] hptr_q, hptr_d;
  logic [PTR_W-1:0] nptr_q, nptr_d;
  logic [TCB_W-1:0] tcb_out_q, tcb_out_d;
  logic             err_q, err_d;

  logic             tick_rise;
  logic             cmd_fire;
  logic             cmd_in_range;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_reject;
  logic             scan_cand;
  logic [PRI_W-1:0] scan_pri;
  logic [PTR_W-1:0] scan_ptr;
  logic             scan_above_rr;
  logic             addr_in_range;
  logic [IDX_W-1:0] addr_idx;
  logic             start_scan;

  assign cmd_ready        = init_done_q && (state_q == S_IDLE) && !pending_q;
  assign cmd_err_out      = err_q;
  assign tcbtask_out      = tcb_out_q;
  assign highpriority_out = hpri_q;
  assign ptr_hpritask_out = hptr_q;
  assign ptr_nexttask_out = nptr_q;
  assign scan_busy_out    = (state_q != S_IDLE);

  assign tick_rise     = tick_in && !tick_q;
  assign cmd_fire      = cmd_valid && cmd_ready;
  assign cmd_in_range  = (32'(cmd_ptr) < NTASKS);
  assign cmd_idx       = cmd_ptr[IDX_W-1:0];
  // The range test is OR-ed first so an out-of-range index never decides.
  assign cmd_reject    = !cmd_in_range ||
                         (((cmd_op == OP_READY) || (cmd_op == OP_BLOCK)) && !valid_q[cmd_idx]);

  assign scan_cand     = valid_q[scan_idx_q] && ready_q[scan_idx_q];
  assign scan_pri      = pri_q[scan_idx_q];
  assign scan_ptr      = PTR_W'(scan_idx_q);
  assign scan_above_rr = (scan_ptr > rr_ptr_q);

  assign addr_in_range = (32'(addrread_in) < NTASKS);
  assign addr_idx      = addrread_in[IDX_W-1:0];

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    init_done_d  = 1'b1;
    tick_d       = tick_in;
    rr_ptr_d     = rr_ptr_q;
    scan_idx_d   = scan_idx_q;
    best_found_d = best_found_q;
    next_found_d = next_found_q;
    best_pri_d   = best_pri_q;
    best_hptr_d  = best_hptr_q;
    best_nptr_d  = best_nptr_q;
    valid_d      = valid_q;
    ready_d      = ready_q;
    pri_d        = pri_q;
    tcb_d        = tcb_q;
    hpri_d       = hpri_q;
    hptr_d       = hptr_q;
    nptr_d       = nptr_q;
    err_d        = 1'b0;
    start_scan   = 1'b0;
    tcb_out_d    = (addr_in_range && valid_q[addr_idx]) ? tcb_q[addr_idx] : '0;

    // The scheduler has just latched ptr_nexttask_out on this tick edge, so
    // that task becomes the round-robin reference for the following scan.
    if (tick_rise) rr_ptr_d = nptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_reject) begin
            err_d = 1'b1;
          end else begin
            start_scan = 1'b1;
            case (cmd_op)
              OP_CREATE: begin
                valid_d[cmd_idx] = 1'b1;
                ready_d[cmd_idx] = 1'b1;
                pri_d[cmd_idx]   = cmd_pri;
                tcb_d[cmd_idx]   = cmd_tcb;
              end
              OP_READY: ready_d[cmd_idx] = 1'b1;
              OP_BLOCK: ready_d[cmd_idx] = 1'b0;
              default: begin
                valid_d[cmd_idx] = 1'b0;
                ready_d[cmd_idx] = 1'b0;
                pri_d[cmd_idx]   = '0;
                tcb_d[cmd_idx]   = '0;
              end
            endcase
          end
        end
        if (tick_rise) start_scan = 1'b1;
      end

      S_SCAN: begin
        if (tick_rise) pending_d = 1'b1;
        if (scan_cand) begin
          if (!best_found_q || (scan_pri > best_pri_q)) begin
            // New best priority: restart both hptr and nptr tracking here.
            best_found_d = 1'b1;
            best_pri_d   = scan_pri;
            best_hptr_d  = scan_ptr;
            best_nptr_d  = scan_ptr;
            next_found_d = scan_above_rr;
          end else if ((scan_pri == best_pri_q) && !next_found_q && scan_above_rr) begin
            best_nptr_d  = scan_ptr;
            next_found_d = 1'b1;
          end
        end
        if (scan_idx_q == LAST_IDX) state_d = S_UPDATE;
        else                        scan_idx_d = scan_idx_q + 1'b1;
      end

      S_UPDATE: begin
        // No candidate leaves best_* at their cleared values: 0/0/0.
        hpri_d = best_pri_q;
        hptr_d = best_hptr_q;
        nptr_d = next_found_q ? best_nptr_q : best_hptr_q;
        if (pending_q || tick_rise) begin
          start_scan = 1'b1;
          pending_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_scan) begin
      state_d      = S_SCAN;
      scan_idx_d   = '0;
      best_found_d = 1'b0;
      next_found_d = 1'b0;
      best_pri_d   = '0;
      best_hptr_d  = '0;
      best_nptr_d  = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      init_done_q  <= 1'b0;
      tick_q       <= 1'b0;
      rr_ptr_q     <= '0;
      scan_idx_q   <= '0;
      best_found_q <= 1'b0;
      next_found_q <= 1'b0;
      best_pri_q   <= '0;
      best_hptr_q  <= '0;
      best_nptr_q  <= '0;
      hpri_q       <= '0;
      hptr_q       <= '0;
      nptr_q       <= '0;
      tcb_out_q    <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < NTASKS; i++) begin
        valid_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
        pri_q[i]   <= '0;
        tcb_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      init_done_q  <= init_done_d;
      tick_q       <= tick_d;
      rr_ptr_q     <= rr_ptr_d;
      scan_idx_q   <= scan_idx_d;
      best_found_q <= best_found_d;
      next_found_q <= next_found_d;
      best_pri_q   <= best_pri_d;
      best_hptr_q  <= best_hptr_d;
      best_nptr_q  <= best_nptr_d;
      hpri_q       <= hpri_d;
      hptr_q       <= hptr_d;
      nptr_q       <= nptr_d;
      tcb_out_q    <= tcb_out_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      pri_q        <= pri_d;
      tcb_q        <= tcb_d;
    end
  end

endmodule

// File: tb/tb_ready_list_manager.sv
// Testbench for ready_list_manager: directed scenarios plus randomized
// commands/ticks, checked against a task-table reference model.
module tb_ready_list_manager;

  localparam int NTASKS = 16;
  localparam int PRI_W  = 6;
  localparam int PTR_W  = 8;
  localparam int TCB_W  = 32;
  localparam int OUT_W  = PRI_W + 2 * PTR_W;

  logic             aclk;
  logic             aresetn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [PTR_W-1:0] cmd_ptr;
  logic [PRI_W-1:0] cmd_pri;
  logic [TCB_W-1:0] cmd_tcb;
  logic             cmd_err_out;
  logic             tick_in;
  logic [PTR_W-1:0] addrread_in;
  logic [TCB_W-1:0] tcbtask_out;
  logic [PRI_W-1:0] highpriority_out;
  logic [PTR_W-1:0] ptr_hpritask_out;
  logic [PTR_W-1:0] ptr_nexttask_out;
  logic             scan_busy_out;
  logic [OUT_W-1:0] dut_sched;

  int checks = 0;
  int passes = 0;

  // Reference model: the task table and the values the scheduler currently sees.
  bit               m_valid [NTASKS];
  bit               m_ready [NTASKS];
  int               m_pri   [NTASKS];
  logic [TCB_W-1:0] m_tcb   [NTASKS];
  int               m_rr;
  logic [OUT_W-1:0] m_pub;
  logic [OUT_W-1:0] exp_q [$];

  ready_list_manager #(
    .NTASKS(NTASKS), .PRI_W(PRI_W), .PTR_W(PTR_W), .TCB_W(TCB_W)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_ptr         (cmd_ptr),
    .cmd_pri         (cmd_pri),
    .cmd_tcb         (cmd_tcb),
    .cmd_err_out     (cmd_err_out),
    .tick_in         (tick_in),
    .addrread_in     (addrread_in),
    .tcbtask_out     (tcbtask_out),
    .highpriority_out(highpriority_out),
    .ptr_hpritask_out(ptr_hpritask_out),
    .ptr_nexttask_out(ptr_nexttask_out),
    .scan_busy_out   (scan_busy_out)
  );

  assign dut_sched = {highpriority_out, ptr_hpritask_out, ptr_nexttask_out};

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < NTASKS; i++) begin
      m_valid[i] = 0; m_ready[i] = 0; m_pri[i] = 0; m_tcb[i] = '0;
    end
    m_rr  = 0;
    m_pub = '0;
  endfunction

  // Returns 1 when the command is rejected (table untouched).
  function automatic bit model_apply(input int op, input int ptr, input int pri,
                                     input logic [TCB_W-1:0] tcb);
    if (ptr >= NTASKS) return 1'b1;
    if ((op == 1 || op == 2) && !m_valid[ptr]) return 1'b1;
    case (op)
      0: begin m_valid[ptr] = 1; m_ready[ptr] = 1; m_pri[ptr] = pri; m_tcb[ptr] = tcb; end
      1: m_ready[ptr] = 1;
      2: m_ready[ptr] = 0;
      default: begin m_valid[ptr] = 0; m_ready[ptr] = 0; m_pri[ptr] = 0; m_tcb[ptr] = '0; end
    endcase
    return 1'b0;
  endfunction

  // Max priority first, then search for the lowest index and the successor.
  function automatic logic [OUT_W-1:0] model_expect();
    int best = -1;
    int hptr = -1;
    int nptr = -1;
    for (int i = 0; i < NTASKS; i++)
      if (m_valid[i] && m_ready[i] && m_pri[i] > best) best = m_pri[i];
    if (best < 0) return '0;
    for (int i = 0; i < NTASKS; i++) begin
      if (m_valid[i] && m_ready[i] && m_pri[i] == best) begin
        if (hptr < 0) hptr = i;
        if (nptr < 0 && i > m_rr) nptr = i;
      end
    end
    if (nptr < 0) nptr = hptr;
    return {PRI_W'(best), PTR_W'(hptr), PTR_W'(nptr)};
  endfunction

  function automatic logic [TCB_W-1:0] model_tcb(input int a);
    if (a >= NTASKS || !m_valid[a]) return '0;
    return m_tcb[a];
  endfunction

  // ---------------- driver tasks (all start/end 1 time unit after a posedge) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input int op, input int ptr, input int pri, input logic [TCB_W-1:0] tcb);
    int waited = 0;
    cmd_op    = 2'(op);
    cmd_ptr   = PTR_W'(ptr);
    cmd_pri   = PRI_W'(pri);
    cmd_tcb   = tcb;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      @(posedge aclk); #1;
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_in = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    tick_in = 1'b0;
    wait_cycles(30);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    wait_cycles(2);
    aresetn = 1'b1;
    model_clear();
    wait_cycles(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int changes = 0;
    wait_cycles(3);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b required 0", cmd_ready); else passes++;
    checks++;
    if ({cmd_err_out, scan_busy_out, tcbtask_out, dut_sched} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {cmd_err_out, scan_busy_out, tcbtask_out, dut_sched});
    else passes++;
    aresetn = 1'b1;
    wait_cycles(1);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", cmd_ready); else passes++;
    for (int i = 0; i < 20; i++) begin
      if ({cmd_err_out, scan_busy_out, dut_sched} !== '0) changes++;
      wait_cycles(1);
    end
    checks++; if (changes !== 0) $display("FAIL idle_quiet: got %0d changed cycles required 0", changes); else passes++;
  endtask

  task automatic test_priority();
    void'(model_apply(0, 3, 5, 32'h1000));
    send_cmd(0, 3, 5, 32'h1000);
    wait_cycles(NTASKS + 1);
    m_pub = model_expect();
    checks++; if (dut_sched !== m_pub) $display("FAIL prio_first: got %h required %h", dut_sched, m_pub); else passes++;
    void'(model_apply(0, 7, 9, 32'h2000));
    send_cmd(0, 7, 9, 32'h2000);
    wait_cycles(NTASKS);
    checks++; if (dut_sched !== m_pub) $display("FAIL prio_hold_during_scan: got %h required %h", dut_sched, m_pub); else passes++;
    checks++; if (scan_busy_out !== 1'b1) $display("FAIL prio_busy: got %b required 1", scan_busy_out); else passes++;
    wait_cycles(1);
    m_pub = model_expect();
    checks++; if (dut_sched !== m_pub) $display("FAIL prio_second_latency: got %h required %h", dut_sched, m_pub); else passes++;
    checks++; if (scan_busy_out !== 1'b0) $display("FAIL prio_busy_done: got %b required 0", scan_busy_out); else passes++;
    for (int k = 0; k < 4; k++) begin
      int a;
      case (k) 0: a = 7; 1: a = 3; 2: a = NTASKS; default: a = 4; endcase
      addrread_in = PTR_W'(a);
      wait_cycles(1);
      checks++;
      if (tcbtask_out !== model_tcb(a)) $display("FAIL tcb_lookup idx %0d: got %h required %h", a, tcbtask_out, model_tcb(a));
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    int exp_n [4] = '{5, 9, 2, 5};
    int idx   [3] = '{2, 5, 9};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      void'(model_apply(0, idx[i], 4, TCB_W'(32'h100 * (i + 1))));
      send_cmd(0, idx[i], 4, TCB_W'(32'h100 * (i + 1)));
      wait_cycles(NTASKS + 1);
    end
    m_pub = model_expect();
    checks++; if (dut_sched !== m_pub) $display("FAIL rr_initial: got %h required %h", dut_sched, m_pub); else passes++;
    for (int t = 0; t < 4; t++) begin
      m_rr = int'(m_pub[PTR_W-1:0]);
      pulse_tick();
      m_pub = model_expect();
      checks++; if (dut_sched !== m_pub) $display("FAIL rr_tick%0d_model: got %h required %h", t, dut_sched, m_pub); else passes++;
      checks++;
      if ({ptr_hpritask_out, ptr_nexttask_out} !== {PTR_W'(2), PTR_W'(exp_n[t])})
        $display("FAIL rr_tick%0d_seq: got hptr %0d nptr %0d required hptr 2 nptr %0d",
                 t, ptr_hpritask_out, ptr_nexttask_out, exp_n[t]);
      else passes++;
    end
  endtask

  task automatic test_block_empty();
    int cidx [4] = '{9, 4, 11, 1};
    int cpri [4] = '{9, 6, 6, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      void'(model_apply(0, cidx[i], cpri[i], TCB_W'(32'h4000 + i)));
      send_cmd(0, cidx[i], cpri[i], TCB_W'(32'h4000 + i));
      wait_cycles(NTASKS + 1);
    end
    m_pub = model_expect();
    checks++; if (dut_sched !== m_pub) $display("FAIL block_setup: got %h required %h", dut_sched, m_pub); else passes++;
    for (int i = 0; i < 4; i++) begin
      void'(model_apply(2, cidx[i], 0, '0));
      send_cmd(2, cidx[i], 0, '0);
      wait_cycles(NTASKS + 1);
      m_pub = model_expect();
      checks++; if (dut_sched !== m_pub) $display("FAIL block_idx%0d: got %h required %h", cidx[i], dut_sched, m_pub); else passes++;
    end
    checks++; if (dut_sched !== '0) $display("FAIL empty_list: got %h required 0", dut_sched); else passes++;
  endtask

  task automatic test_errors();
    int eop  [3] = '{1, 0, 2};
    int eptr [3] = '{4, NTASKS, 13};
    do_reset();
    void'(model_apply(0, 2, 3, 32'h3000));
    send_cmd(0, 2, 3, 32'h3000);
    wait_cycles(NTASKS + 1);
    m_pub = model_expect();
    for (int i = 0; i < 3; i++) begin
      bit exp_err;
      int busy_seen = 0;
      exp_err = model_apply(eop[i], eptr[i], 7, 32'hdead);
      send_cmd(eop[i], eptr[i], 7, 32'hdead);
      checks++; if (cmd_err_out !== exp_err) $display("FAIL err_pulse%0d: got %b required %b", i, cmd_err_out, exp_err); else passes++;
      for (int c = 0; c < NTASKS + 4; c++) begin
        if (scan_busy_out !== 1'b0) busy_seen++;
        wait_cycles(1);
        if (c == 0) begin
          checks++; if (cmd_err_out !== 1'b0) $display("FAIL err_one_cycle%0d: got %b required 0", i, cmd_err_out); else passes++;
        end
      end
      checks++; if (busy_seen !== 0) $display("FAIL err_no_scan%0d: got %0d busy cycles required 0", i, busy_seen); else passes++;
      checks++; if (dut_sched !== m_pub) $display("FAIL err_unchanged%0d: got %h required %h", i, dut_sched, m_pub); else passes++;
    end
  endtask

  task automatic test_tick_during_scan();
    int bad = 0;
    do_reset();
    void'(model_apply(0, 2, 3, 32'h5000));
    send_cmd(0, 2, 3, 32'h5000);
    wait_cycles(NTASKS + 1);
    m_pub = model_expect();
    void'(model_apply(0, 6, 3, 32'h6000));
    send_cmd(0, 6, 3, 32'h6000);
    for (int k = 0; k <= 2 * NTASKS + 1; k++) begin
      if (cmd_ready !== 1'b0) bad++;
      if (k == 2) begin
        tick_in = 1'b1;
        m_rr = int'(m_pub[PTR_W-1:0]);
      end
      if (k == 5) tick_in = 1'b0;
      wait_cycles(1);
    end
    checks++; if (bad !== 0) $display("FAIL tds_ready_low: got %0d ready cycles required 0", bad); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL tds_ready_return: got %b required 1", cmd_ready); else passes++;
    m_pub = model_expect();
    checks++; if (dut_sched !== m_pub) $display("FAIL tds_final: got %h required %h", dut_sched, m_pub); else passes++;
  endtask

  task automatic test_mid_scan_reset();
    void'(model_apply(0, 5, 7, 32'h7000));
    send_cmd(0, 5, 7, 32'h7000);
    wait_cycles(5);
    aresetn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, scan_busy_out, dut_sched} !== '0)
      $display("FAIL midscan_reset_clear: got %h required 0", {cmd_ready, scan_busy_out, dut_sched});
    else passes++;
    wait_cycles(2);
    aresetn = 1'b1;
    model_clear();
    wait_cycles(NTASKS + 5);
    checks++;
    if ({scan_busy_out, dut_sched} !== '0)
      $display("FAIL midscan_no_update: got %h required 0", {scan_busy_out, dut_sched});
    else passes++;
    addrread_in = PTR_W'(5);
    wait_cycles(1);
    checks++; if (tcbtask_out !== '0) $display("FAIL midscan_tcb_cleared: got %h required 0", tcbtask_out); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int op, ptr, pri, a;
      logic [TCB_W-1:0] tcb;
      bit exp_err;
      op  = $urandom_range(0, 4);
      if (op == 4) op = 0;
      ptr = $urandom_range(0, NTASKS);
      pri = $urandom_range(0, 7);
      tcb = $urandom;
      exp_err = model_apply(op, ptr, pri, tcb);
      send_cmd(op, ptr, pri, tcb);
      checks++; if (cmd_err_out !== exp_err) $display("FAIL rand_err it%0d: got %b required %b", it, cmd_err_out, exp_err); else passes++;
      if (!exp_err) begin
        exp_q.push_back(model_expect());
        wait_cycles(NTASKS + 1);
        m_pub = exp_q.pop_front();
      end else begin
        wait_cycles(2);
        checks++; if (scan_busy_out !== 1'b0) $display("FAIL rand_err_busy it%0d: got %b required 0", it, scan_busy_out); else passes++;
      end
      checks++; if (dut_sched !== m_pub) $display("FAIL rand_sched it%0d: got %h required %h", it, dut_sched, m_pub); else passes++;
      if ($urandom_range(0, 3) == 0) begin
        m_rr = int'(m_pub[PTR_W-1:0]);
        pulse_tick();
        m_pub = model_expect();
        checks++; if (dut_sched !== m_pub) $display("FAIL rand_tick it%0d: got %h required %h", it, dut_sched, m_pub); else passes++;
      end
      a = $urandom_range(0, NTASKS);
      addrread_in = PTR_W'(a);
      wait_cycles(1);
      checks++; if (tcbtask_out !== model_tcb(a)) $display("FAIL rand_tcb it%0d idx %0d: got %h required %h", it, a, tcbtask_out, model_tcb(a)); else passes++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    aresetn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_ptr     = '0;
    cmd_pri     = '0;
    cmd_tcb     = '0;
    tick_in     = 1'b0;
    addrread_in = '0;
    model_clear();
    test_reset();
    test_priority();
    test_round_robin();
    test_block_empty();
    test_errors();
    test_tick_during_scan();
    test_mid_scan_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
